// File: rtl/fc_pkg.sv
// Shared definitions for the fc classifier stage: default geometry and the
// argmax controller state encoding.
package fc_pkg;

    localparam int FC_N_CLASS = 10;
    localparam int FC_SCORE_W = 32;
    localparam int FC_IDX_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/fc_argmax.sv
// Final CNN stage: captures one score per class and scans them serially,
// one signed compare per cycle, reporting the first index holding the maximum.
//
//   state | meaning
//   IDLE  | waiting for a score set on ivalid
//   SCAN  | comparing sc[idx] against the running best, one class per cycle
//   DONE  | ovalid pulse; a new set may be accepted in this same cycle
module fc_argmax
    import fc_pkg::*;
#(
    parameter int N_CLASS = FC_N_CLASS,
    parameter int SCORE_W = FC_SCORE_W,
    parameter int IDX_W   = FC_IDX_W
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        ivalid,
    input  logic [N_CLASS*SCORE_W-1:0]  din,
    output logic                        ovalid,
    output logic [IDX_W-1:0]            class_id,
    output logic signed [SCORE_W-1:0]   max_score,
    output logic                        busy,
    output logic                        overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);

    argmax_state_t state, state_nxt;

    logic signed [SCORE_W-1:0] sc [N_CLASS];
    logic signed [SCORE_W-1:0] best;
    logic signed [SCORE_W-1:0] cur;
    logic [IDX_W-1:0]          best_idx;
    logic [IDX_W-1:0]          idx;
    logic                      accept;
    logic                      idx_bad;
    logic                      last;
    logic                      take;

    // DONE accepts like IDLE so back-to-back sets lose no cycle.
    assign accept  = ivalid && (state == ST_IDLE || state == ST_DONE);
    assign idx_bad = (idx > LAST_IDX);
    assign last    = (idx == LAST_IDX);

    always_comb begin
        cur = '0;
        for (int k = 0; k < N_CLASS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur = sc[k];
            end
        end
    end

    // Strict compare keeps the lowest index on ties.
    assign take = (cur > best);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ivalid) begin
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (idx_bad) begin
                    state_nxt = ST_IDLE;
                end else if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ivalid ? ST_SCAN : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Score buffer is deliberately left out of reset; it is always loaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < N_CLASS; k++) begin
                sc[k] <= din[k*SCORE_W +: SCORE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            best      <= '0;
            best_idx  <= '0;
            idx       <= '0;
            class_id  <= '0;
            max_score <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= ivalid && (state == ST_SCAN);
            if (accept) begin
                best     <= din[SCORE_W-1:0];
                best_idx <= '0;
                idx      <= IDX_W'(1);
            end else if (state == ST_SCAN && !idx_bad) begin
                if (take) begin
                    best     <= cur;
                    best_idx <= idx;
                end
                idx <= idx + IDX_W'(1);
                if (last) begin
                    class_id  <= take ? idx : best_idx;
                    max_score <= take ? cur : best;
                end
            end
        end
    end

    assign ovalid = (state == ST_DONE);
    assign busy   = (state == ST_SCAN);

endmodule

// File: tb/tb_fc_argmax.sv
// Randomized scoreboard bench for fc_argmax: stimulus pushes expected results,
// a negedge monitor pops and compares whenever the DUT reports.
module tb_fc_argmax;

    localparam int N  = 10;
    localparam int W  = 32;
    localparam int IW = 4;

    typedef logic signed [W-1:0] score_t;
    typedef struct {
        int     cls;
        score_t score;
        int     cyc;
    } exp_t;

    logic                 clk;
    logic                 rstn;
    logic                 ivalid;
    logic [N*W-1:0]       din;
    logic                 ovalid;
    logic [IW-1:0]        class_id;
    logic signed [W-1:0]  max_score;
    logic                 busy;
    logic                 overrun;

    fc_argmax #(.N_CLASS(N), .SCORE_W(W), .IDX_W(IW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ivalid    (ivalid),
        .din       (din),
        .ovalid    (ovalid),
        .class_id  (class_id),
        .max_score (max_score),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     vectors     = 0;
    int     miscompares = 0;
    exp_t   expq[$];
    int     ovq[$];
    int     busy_lo     = 0;
    int     busy_hi     = -1;
    int     free_cyc    = 0;
    int     held_cls    = 0;
    score_t held_score  = '0;
    bit     started     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: find the maximum value, then the first class that holds it.
    function automatic void ref_argmax(input score_t s [N], output int cls, output score_t mx);
        mx = s[0];
        foreach (s[k]) if (s[k] > mx) mx = s[k];
        cls = -1;
        for (int k = N - 1; k >= 0; k--) if (s[k] == mx) cls = k;
    endfunction

    task automatic send(input score_t s [N]);
        exp_t e;
        for (int k = 0; k < N; k++) din[k*W +: W] = s[k];
        ivalid = 1'b1;
        if (cyc >= free_cyc) begin
            ref_argmax(s, e.cls, e.score);
            e.cyc = cyc + N;
            expq.push_back(e);
            busy_lo  = cyc + 1;
            busy_hi  = cyc + N - 1;
            free_cyc = cyc + N;
        end else begin
            ovq.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        ivalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rstn && started) begin
            exp_t e;
            bit   exp_ov;
            chk("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
            exp_ov = (ovq.size() > 0 && ovq[0] == cyc);
            if (exp_ov) void'(ovq.pop_front());
            chk("overrun", 64'(overrun), 64'(exp_ov));
            if (ovalid) begin
                if (expq.size() == 0) begin
                    chk("ovalid_unexpected", 64'(ovalid), 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("ovalid_cycle", 64'(cyc), 64'(e.cyc));
                    held_cls   = e.cls;
                    held_score = e.score;
                end
            end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                e = expq.pop_front();
                chk("ovalid_missing", 64'(ovalid), 64'd1);
                held_cls   = e.cls;
                held_score = e.score;
            end
            chk("class_id", 64'(class_id), 64'(held_cls));
            chk("max_score", 64'(unsigned'(max_score)), 64'(unsigned'(held_score)));
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_ovalid", 64'(ovalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_class_id", 64'(class_id), 64'd0);
        chk("rst_max_score", 64'(unsigned'(max_score)), 64'd0);
    endtask

    task automatic model_flush();
        expq.delete();
        ovq.delete();
        busy_hi    = -1;
        free_cyc   = 0;
        held_cls   = 0;
        held_score = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        score_t s1 [N] = '{5, -3, 12, 0, 7, 99, -50, 1234, 8, 1};
        score_t s2 [N];
        score_t s3 [N];
        score_t sr [N];
        int     mode;

        rstn   = 1'b0;
        ivalid = 1'b0;
        din    = '0;
        #12;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rstn    = 1'b1;
        started = 1'b1;
        idle(2);

        send(s1);
        idle(N + 2);

        foreach (s2[k]) s2[k] = -5;
        send(s2);
        idle(N + 1);
        foreach (s3[k]) s3[k] = score_t'(-100 + 10 * k);
        send(s3);
        idle(N + 1);

        foreach (s3[k]) s3[k] = 32'h8000_0000;
        s3[0] = 32'h7FFF_FFFF;
        send(s3);
        idle(N + 1);
        s3[0] = 32'h8000_0000;
        s3[N-1] = 32'h7FFF_FFFF;
        send(s3);
        idle(N + 1);

        // Second set arrives mid-scan and must be dropped.
        send(s1);
        idle(2);
        send(s2);
        idle(N + 4);

        // Second set lands exactly in the DONE cycle.
        send(s3);
        idle(N - 1);
        foreach (s2[k]) s2[k] = score_t'(k * 3 - 7);
        send(s2);
        idle(N + 2);

        // Reset in the middle of a scan.
        send(s1);
        idle(3);
        rstn = 1'b0;
        model_flush();
        #1;
        chk_reset_outputs();
        idle(2);
        rstn = 1'b1;
        idle(1);
        send(s3);
        idle(N + 2);

        for (int t = 0; t < 40; t++) begin
            mode = $urandom_range(0, 2);
            foreach (sr[k]) begin
                case (mode)
                    0:       sr[k] = score_t'($urandom);
                    1:       sr[k] = score_t'($urandom_range(0, 6)) - 3;
                    default: sr[k] = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
                endcase
            end
            send(sr);
            idle($urandom_range(0, 13));
        end
        idle(N + 3);

        vectors++;
        if (expq.size() != 0 || ovq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d results %0d overruns outstanding, expected 0", expq.size(), ovq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
